// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF and MEM.
// MEM has priority; IF is owed the next grant after every data access.
module mem_port_arbiter #(
  parameter int LAT = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          stall_f,
  output logic          stall_m
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam logic [3:0] CNT0 = 4'(LAT);

  state_t     st;
  logic [3:0] cnt;
  logic       killed;
  logic       if_owed;
  logic       if_ok;
  logic       d_ok;
  logic       gnt_d;
  logic       gnt_i;
  logic       last;

  // a requester whose done pulse is high cannot win again this cycle
  assign if_ok = if_req & ~if_kill & ~if_done;
  assign d_ok  = d_req & ~d_done;
  assign gnt_d = d_ok & ~(if_owed & if_ok);
  assign gnt_i = if_ok & ~gnt_d;
  assign last  = (cnt == 4'd1);

  assign stall_m = d_req & ~d_done;
  assign stall_f = (if_req & ~if_done) | stall_m;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st       <= IDLE;
      cnt      <= '0;
      killed   <= 1'b0;
      if_owed  <= 1'b0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      unique case (st)
        IDLE: begin
          if (gnt_d) begin
            st      <= BUSY_D;
            m_en    <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            cnt     <= CNT0;
          end else if (gnt_i) begin
            st      <= BUSY_I;
            m_en    <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= if_addr;
            cnt     <= CNT0;
            if_owed <= 1'b0;
          end
        end
        BUSY_I: begin
          cnt <= cnt - 4'd1;
          if (if_kill) killed <= 1'b1;
          if (last) begin
            st     <= IDLE;
            m_en   <= 1'b0;
            killed <= 1'b0;
            // a kill in the final cycle still suppresses the result
            if (!(killed | if_kill)) begin
              if_rdata <= m_rdata;
              if_done  <= 1'b1;
            end
          end
        end
        BUSY_D: begin
          cnt <= cnt - 4'd1;
          if (last) begin
            st     <= IDLE;
            m_en   <= 1'b0;
            d_done <= 1'b1;
            if (!m_we) d_rdata <= m_rdata;
            if (if_req) if_owed <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
